// File: rtl/counter_modn_if.sv
// Bus bundle for counter_modn: control inputs and count/status outputs of one digit stage.
// The preset lines exist only when COUNTER_MODN_LOAD_EN is defined.
interface counter_modn_if #(
  parameter int WIDTH = 3
);
  logic             ena;
  logic             clr;
  logic             dir;
`ifdef COUNTER_MODN_LOAD_EN
  logic             load;
  logic [WIDTH-1:0] load_val;
`endif
  logic [WIDTH-1:0] cnt;
  logic             at_max;
  logic             at_min;
  logic             carry;
  logic             borrow;

  modport master (
`ifdef COUNTER_MODN_LOAD_EN
    output load, load_val,
`endif
    output ena, clr, dir,
    input  cnt, at_max, at_min, carry, borrow
  );

  modport slave (
`ifdef COUNTER_MODN_LOAD_EN
    input  load, load_val,
`endif
    input  ena, clr, dir,
    output cnt, at_max, at_min, carry, borrow
  );
endinterface

// File: rtl/counter_modn.sv
// Modulo-N up/down digit counter with clear, cascade carry/borrow and coherent max/min flags.
// Optional saturating preset load is enabled by defining COUNTER_MODN_LOAD_EN.
module counter_modn #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 6
) (
  input  logic          clk,
  input  logic          rst,
  counter_modn_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

  if ((WIDTH < 1) || (MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_params
    $error("counter_modn: illegal WIDTH/MODULUS combination");
  end

  logic             w_load;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] r_cnt;
  logic             r_at_max;
  logic             r_at_min;

`ifdef COUNTER_MODN_LOAD_EN
  assign w_load     = bus.load;
  assign w_load_val = bus.load_val;
`else
  assign w_load     = 1'b0;
  assign w_load_val = ZERO_VAL;
`endif

  always_comb begin
    w_next = r_cnt;
    if (bus.clr) begin
      w_next = ZERO_VAL;
    end else if (w_load) begin
      // Out-of-range presets saturate so the count never leaves 0..MODULUS-1.
      w_next = (w_load_val > MAX_VAL) ? MAX_VAL : w_load_val;
    end else if (bus.ena) begin
      if (bus.dir) begin
        w_next = (r_cnt == ZERO_VAL) ? MAX_VAL : (r_cnt - ONE_VAL);
      end else begin
        w_next = (r_cnt == MAX_VAL) ? ZERO_VAL : (r_cnt + ONE_VAL);
      end
    end else begin
      w_next = r_cnt;
    end
  end

  // Flags are derived from the next value so they land on the same edge as the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= ZERO_VAL;
      r_at_max <= 1'b0;
      r_at_min <= 1'b1;
    end else begin
      r_cnt    <= w_next;
      r_at_max <= (w_next == MAX_VAL);
      r_at_min <= (w_next == ZERO_VAL);
    end
  end

  assign bus.cnt    = r_cnt;
  assign bus.at_max = r_at_max;
  assign bus.at_min = r_at_min;
  assign bus.carry  = bus.ena & ~bus.dir & r_at_max & ~bus.clr & ~w_load;
  assign bus.borrow = bus.ena &  bus.dir & r_at_min & ~bus.clr & ~w_load;
endmodule

// File: tb/tb_counter_modn.sv
// Self-checking bench for counter_modn: a mod-6 digit cascaded into a mod-10 digit,
// compared against a modular-arithmetic reference model.
module tb_counter_modn;
  localparam int W  = 3;
  localparam int M  = 6;
  localparam int WB = 4;
  localparam int MB = 10;

  logic clk = 1'b0;
  logic rst;
  logic ld;
  logic [W-1:0] ld_val;

  int n_tests = 0;
  int n_fail  = 0;
  int m_a     = 0;
  int m_b     = 0;

  always #5 clk = ~clk;

  counter_modn_if #(.WIDTH(W))  ifa ();
  counter_modn_if #(.WIDTH(WB)) ifb ();

  counter_modn #(.WIDTH(W),  .MODULUS(M))  dut_a (.clk(clk), .rst(rst), .bus(ifa));
  counter_modn #(.WIDTH(WB), .MODULUS(MB)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  assign ifb.ena = ifa.carry;
  assign ifb.dir = 1'b0;
  assign ifb.clr = 1'b0;
`ifdef COUNTER_MODN_LOAD_EN
  assign ifa.load     = ld;
  assign ifa.load_val = ld_val;
  assign ifb.load     = 1'b0;
  assign ifb.load_val = 4'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_carry();
    return (ifa.ena && !ifa.dir && (m_a == M - 1) && !ifa.clr && !ld) ? 1 : 0;
  endfunction

  function automatic int exp_borrow();
    return (ifa.ena && ifa.dir && (m_a == 0) && !ifa.clr && !ld) ? 1 : 0;
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, "_cnt"},    32'(ifa.cnt),    32'(m_a));
    chk({tag, "_at_max"}, 32'(ifa.at_max), (m_a == M - 1) ? 32'd1 : 32'd0);
    chk({tag, "_at_min"}, 32'(ifa.at_min), (m_a == 0) ? 32'd1 : 32'd0);
    chk({tag, "_cnt_b"},  32'(ifb.cnt),    32'(m_b));
  endtask

  // One clock: check cascade outputs before the edge, advance the model, check state after it.
  task automatic cycle(input string tag);
    int c;
    int b;
    #1;
    c = exp_carry();
    b = exp_borrow();
    chk({tag, "_carry"},  32'(ifa.carry),  32'(c));
    chk({tag, "_borrow"}, 32'(ifa.borrow), 32'(b));
    @(posedge clk);
    if (c == 1) m_b = (m_b + 1) % MB;
    if (ifa.clr)            m_a = 0;
    else if (ld)            m_a = (int'(ld_val) >= M) ? M - 1 : int'(ld_val);
    else if (ifa.ena)       m_a = ifa.dir ? (m_a + M - 1) % M : (m_a + 1) % M;
    #1;
    chk_state(tag);
  endtask

  task automatic set_in(input logic e, input logic d, input logic c);
    ifa.ena = e;
    ifa.dir = d;
    ifa.clr = c;
    ld      = 1'b0;
    ld_val  = 3'd0;
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0);
    #12;
    chk_state("reset");
    rst = 1'b0;

    // Test 1: asynchronous reset in the middle of counting.
    set_in(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle("t1_up");
    chk("t1_pre_cnt", 32'(ifa.cnt), 32'd4);
    #2 rst = 1'b1;
    #1;
    m_a = 0;
    m_b = 0;
    chk_state("t1_async");
    #1 rst = 1'b0;

    // Test 2: seven up-steps from 0, through the wrap.
    for (int i = 0; i < 7; i++) cycle("t2_up");
    chk("t2_final", 32'(ifa.cnt), 32'd1);

    // Test 3: count down from 0, then reverse direction at 3.
    set_in(1'b0, 1'b0, 1'b1);
    cycle("t3_clr");
    set_in(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("t3_dn");
    chk("t3_at3", 32'(ifa.cnt), 32'd3);
    ifa.dir = 1'b0;
    cycle("t3_rev");
    chk("t3_rev_cnt", 32'(ifa.cnt), 32'd4);

    // Test 4: hold at 2 with ena low.
    set_in(1'b0, 1'b0, 1'b1);
    cycle("t4_clr");
    set_in(1'b1, 1'b0, 1'b0);
    cycle("t4_up");
    cycle("t4_up");
    set_in(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle("t4_hold");
    chk("t4_held", 32'(ifa.cnt), 32'd2);

    // Test 5: clear beats load and discards the count step at MODULUS-1.
    set_in(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("t5_up");
    ifa.clr = 1'b1;
`ifdef COUNTER_MODN_LOAD_EN
    ld     = 1'b1;
    ld_val = 3'd3;
`endif
    cycle("t5_clr");
    chk("t5_clr_cnt", 32'(ifa.cnt), 32'd0);
`ifdef COUNTER_MODN_LOAD_EN
    ifa.clr = 1'b0;
    ld      = 1'b1;
    ld_val  = 3'd7;
    cycle("t5_load_sat");
    chk("t5_sat_cnt", 32'(ifa.cnt), 32'd5);
`endif

    // Random mix of enable, direction, rare clear and rare preset.
    for (int i = 0; i < 300; i++) begin
      ifa.ena = 1'($urandom_range(0, 3) != 0);
      ifa.dir = 1'($urandom_range(0, 1));
      ifa.clr = 1'($urandom_range(0, 15) == 0);
      ld      = 1'b0;
      ld_val  = 3'($urandom_range(0, 7));
`ifdef COUNTER_MODN_LOAD_EN
      ld      = 1'($urandom_range(0, 9) == 0);
`endif
      cycle("rnd");
    end

    // Test 6: 60 up-steps through the cascade; upper mod-10 stage returns to 0.
    set_in(1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    m_a = 0;
    m_b = 0;
    chk_state("t6_reset");
    #1 rst = 1'b0;
    set_in(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) cycle("t6_casc");
    chk("t6_upper_wrap", 32'(ifb.cnt), 32'd0);
    chk("t6_lower",      32'(ifa.cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
